// File: rtl/mpy_sequencer_if.sv
// Request, multiplier and writeback signals of the MPY sequencer.
interface mpy_sequencer_if #(
  parameter int DW = 16,
  parameter int MW = 18
);
  logic            start;
  logic [DW-1:0]   op_src;
  logic [DW-1:0]   op_dst;
  logic            is_signed;
  logic            busy;
  logic [MW-1:0]   mul_a;
  logic [MW-1:0]   mul_b;
  logic [2*MW-1:0] mul_p;
  logic            mul_done;
  logic            wr_req;
  logic            wr_sel;
  logic [DW-1:0]   wr_data;
  logic            wr_ack;
  logic            op_done;

  modport slave (
    input  start, op_src, op_dst, is_signed,
    input  mul_p, mul_done, wr_ack,
    output busy, mul_a, mul_b,
    output wr_req, wr_sel, wr_data, op_done
  );

  modport master (
    output start, op_src, op_dst, is_signed,
    output mul_p, mul_done, wr_ack,
    input  busy, mul_a, mul_b,
    input  wr_req, wr_sel, wr_data, op_done
  );
endinterface

// File: rtl/mpy_sequencer.sv
// MPY front/back end for the shared 18x18 multiplier; two-beat writeback.
// Define MPY_SIGNED_EN to enable sign-magnitude handling of is_signed.
module mpy_sequencer #(
  parameter int DW            = 16,
  parameter int MW            = 18,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  mpy_sequencer_if.slave bus
);
  localparam int PW = 2 * DW;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_WR_HI,
    S_WR_LO
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [MW-1:0] r_a, w_a_nxt;
  logic [MW-1:0] r_b, w_b_nxt;
  logic          r_neg, w_neg_nxt;
  logic [PW-1:0] r_prod, w_prod_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_wr_req, w_wr_req_nxt;
  logic          r_wr_sel, w_wr_sel_nxt;
  logic [DW-1:0] r_wr_data, w_wr_data_nxt;
  logic          r_op_done, w_op_done_nxt;

  logic          w_sgn_req;
  logic [DW-1:0] w_mag_src;
  logic [DW-1:0] w_mag_dst;
  logic [PW-1:0] w_cap;
  logic          w_unused;

`ifdef MPY_SIGNED_EN
  assign w_sgn_req = bus.is_signed;
`else
  assign w_sgn_req = 1'b0;
`endif

  // -32768 maps onto itself, which reads back as magnitude 0x8000
  assign w_mag_src = (w_sgn_req && bus.op_src[DW-1]) ?
                     (~bus.op_src + 1'b1) : bus.op_src;
  assign w_mag_dst = (w_sgn_req && bus.op_dst[DW-1]) ?
                     (~bus.op_dst + 1'b1) : bus.op_dst;

  assign w_cap = r_neg ? (~bus.mul_p[PW-1:0] + 1'b1)
                       : bus.mul_p[PW-1:0];

  assign w_unused = ^{bus.mul_p[2*MW-1:PW], bus.is_signed};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_prod    <= '0;
      r_busy    <= 1'b0;
      r_wr_req  <= 1'b0;
      r_wr_sel  <= 1'b0;
      r_wr_data <= '0;
      r_op_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_neg     <= w_neg_nxt;
      r_prod    <= w_prod_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_req  <= w_wr_req_nxt;
      r_wr_sel  <= w_wr_sel_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_op_done <= w_op_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_neg_nxt     = r_neg;
    w_prod_nxt    = r_prod;
    w_busy_nxt    = r_busy;
    w_wr_req_nxt  = r_wr_req;
    w_wr_sel_nxt  = r_wr_sel;
    w_wr_data_nxt = r_wr_data;
    w_op_done_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt     = {{(MW-DW){1'b0}}, w_mag_src};
          w_b_nxt     = {{(MW-DW){1'b0}}, w_mag_dst};
          w_neg_nxt   = w_sgn_req &
                        (bus.op_src[DW-1] ^ bus.op_dst[DW-1]);
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = CW'(SETTLE_CYCLES - 1);
          w_state_nxt = S_SETTLE;
        end
      end
      // multiplier done is stale right after an operand change
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mul_done) begin
          w_prod_nxt    = w_cap;
          w_wr_req_nxt  = 1'b1;
          w_wr_sel_nxt  = 1'b0;
          w_wr_data_nxt = w_cap[PW-1:DW];
          w_state_nxt   = S_WR_HI;
        end
      end
      S_WR_HI: begin
        if (bus.wr_ack) begin
          w_wr_sel_nxt  = 1'b1;
          w_wr_data_nxt = r_prod[DW-1:0];
          w_state_nxt   = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (bus.wr_ack) begin
          w_wr_req_nxt  = 1'b0;
          w_wr_sel_nxt  = 1'b0;
          w_busy_nxt    = 1'b0;
          w_op_done_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy    = r_busy;
  assign bus.mul_a   = r_a;
  assign bus.mul_b   = r_b;
  assign bus.wr_req  = r_wr_req;
  assign bus.wr_sel  = r_wr_sel;
  assign bus.wr_data = r_wr_data;
  assign bus.op_done = r_op_done;
endmodule
